// File: rtl/reorder_buffer.sv
// In-order reorder buffer: circular entry store, N writeback ports, single commit per cycle, full flush on mispredict.
// Optional ROB_WB_BYPASS_EN forwards same-cycle writebacks to the operand query ports.
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_N   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic [1:0]               alloc_kind,
    input  logic [REG_W-1:0]         alloc_dest,
    input  logic                     alloc_pred_taken,
    input  logic [WB_N*TAG_W-1:0]    wb_tag,
    input  logic [WB_N*DATA_W-1:0]   wb_value,
    input  logic [WB_N-1:0]          wb_taken,
    input  logic [TAG_W-1:0]         q_tag1,
    input  logic [TAG_W-1:0]         q_tag2,
    output logic                     q_ready1,
    output logic                     q_ready2,
    output logic [DATA_W-1:0]        q_value1,
    output logic [DATA_W-1:0]        q_value2,
    output logic [REG_W-1:0]         cm_reg_tag,
    output logic [DATA_W-1:0]        cm_reg_value,
    output logic [TAG_W-1:0]         cm_store_tag,
    output logic                     flush,
    output logic [DATA_W-1:0]        flush_addr,
    output logic [TAG_W-1:0]         count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {K_REG = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2, K_JALR = 2'd3} kind_e;

    logic              valid_q [DEPTH], valid_d [DEPTH];
    logic              ready_q [DEPTH], ready_d [DEPTH];
    kind_e             kind_q  [DEPTH], kind_d  [DEPTH];
    logic [REG_W-1:0]  dest_q  [DEPTH], dest_d  [DEPTH];
    logic              pred_q  [DEPTH], pred_d  [DEPTH];
    logic              taken_q [DEPTH], taken_d [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH], value_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TAG_W-1:0]  count_q, count_d;
    logic [REG_W-1:0]  cm_reg_tag_q, cm_reg_tag_d;
    logic [DATA_W-1:0] cm_reg_value_q, cm_reg_value_d;
    logic [TAG_W-1:0]  cm_store_tag_q, cm_store_tag_d;
    logic              flush_q, flush_d;
    logic [DATA_W-1:0] flush_addr_q, flush_addr_d;
    logic              head_ok_s, flush_cond_s, alloc_fire_s;

    // Entry i is always addressed by tag i+1; tag 0 therefore never matches.
    function automatic logic [TAG_W-1:0] tag_of(input int idx);
        return TAG_W'(idx + 1);
    endfunction

    assign head_ok_s    = valid_q[head_q] && ready_q[head_q];
    assign flush_cond_s = head_ok_s && ((kind_q[head_q] == K_JALR) ||
                          ((kind_q[head_q] == K_BRANCH) && (taken_q[head_q] != pred_q[head_q])));
    assign full         = (count_q == TAG_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign alloc_ready  = !full && !flush_cond_s;
    assign alloc_fire_s = alloc_valid && alloc_ready;
    assign alloc_tag    = TAG_W'(tail_q) + TAG_W'(1);
    assign count        = count_q;
    assign cm_reg_tag   = cm_reg_tag_q;
    assign cm_reg_value = cm_reg_value_q;
    assign cm_store_tag = cm_store_tag_q;
    assign flush        = flush_q;
    assign flush_addr   = flush_addr_q;

    // Operand query from stored state, optionally overridden by live writebacks.
    always_comb begin
        q_ready1 = 1'b0;
        q_value1 = '0;
        q_ready2 = 1'b0;
        q_value2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (q_tag1 == tag_of(i))) begin
                q_ready1 = ready_q[i];
                q_value1 = value_q[i];
            end else begin
                q_ready1 = q_ready1;
            end
            if (valid_q[i] && (q_tag2 == tag_of(i))) begin
                q_ready2 = ready_q[i];
                q_value2 = value_q[i];
            end else begin
                q_ready2 = q_ready2;
            end
        end
`ifdef ROB_WB_BYPASS_EN
        for (int p = 0; p < WB_N; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (wb_tag[p*TAG_W +: TAG_W] == tag_of(i)) && (q_tag1 == tag_of(i))) begin
                    q_ready1 = 1'b1;
                    q_value1 = wb_value[p*DATA_W +: DATA_W];
                end else begin
                    q_ready1 = q_ready1;
                end
                if (valid_q[i] && (wb_tag[p*TAG_W +: TAG_W] == tag_of(i)) && (q_tag2 == tag_of(i))) begin
                    q_ready2 = 1'b1;
                    q_value2 = wb_value[p*DATA_W +: DATA_W];
                end else begin
                    q_ready2 = q_ready2;
                end
            end
        end
`endif
    end

    // Next state: writeback, allocation, then commit/flush (commit and flush override earlier updates).
    always_comb begin
        valid_d        = valid_q;
        ready_d        = ready_q;
        kind_d         = kind_q;
        dest_d         = dest_q;
        pred_d         = pred_q;
        taken_d        = taken_q;
        value_d        = value_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        cm_reg_tag_d   = '0;
        cm_reg_value_d = '0;
        cm_store_tag_d = '0;
        flush_d        = 1'b0;
        flush_addr_d   = '0;
        for (int p = 0; p < WB_N; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (wb_tag[p*TAG_W +: TAG_W] == tag_of(i))) begin
                    ready_d[i] = 1'b1;
                    value_d[i] = wb_value[p*DATA_W +: DATA_W];
                    taken_d[i] = wb_taken[p];
                end else begin
                    ready_d[i] = ready_d[i];
                end
            end
        end
        if (alloc_fire_s) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            kind_d[tail_q]  = kind_e'(alloc_kind);
            dest_d[tail_q]  = alloc_dest;
            pred_d[tail_q]  = alloc_pred_taken;
            taken_d[tail_q] = 1'b0;
            value_d[tail_q] = '0;
            tail_d          = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        if (flush_cond_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_d[i] = 1'b0;
                ready_d[i] = 1'b0;
            end
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            flush_d      = 1'b1;
            flush_addr_d = value_q[head_q];
        end else if (head_ok_s) begin
            case (kind_q[head_q])
                K_REG: begin
                    cm_reg_tag_d   = dest_q[head_q];
                    cm_reg_value_d = value_q[head_q];
                end
                K_STORE: cm_store_tag_d = TAG_W'(head_q) + TAG_W'(1);
                default: cm_reg_tag_d = '0;
            endcase
            valid_d[head_q] = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
            count_d         = alloc_fire_s ? count_q : count_q - TAG_W'(1);
        end else begin
            count_d = alloc_fire_s ? count_q + TAG_W'(1) : count_q;
        end
    end

    // State and registered commit/flush pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ready_q[i] <= 1'b0;
                kind_q[i]  <= K_REG;
                dest_q[i]  <= '0;
                pred_q[i]  <= 1'b0;
                taken_q[i] <= 1'b0;
                value_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            cm_reg_tag_q   <= '0;
            cm_reg_value_q <= '0;
            cm_store_tag_q <= '0;
            flush_q        <= 1'b0;
            flush_addr_q   <= '0;
        end else begin
            valid_q        <= valid_d;
            ready_q        <= ready_d;
            kind_q         <= kind_d;
            dest_q         <= dest_d;
            pred_q         <= pred_d;
            taken_q        <= taken_d;
            value_q        <= value_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            cm_reg_tag_q   <= cm_reg_tag_d;
            cm_reg_value_q <= cm_reg_value_d;
            cm_store_tag_q <= cm_store_tag_d;
            flush_q        <= flush_d;
            flush_addr_q   <= flush_addr_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (DEPTH=4, two writeback ports); commits are checked against a scoreboard queue.
module tb_reorder_buffer;
    localparam int DEPTH = 4, TAG_W = 4, DATA_W = 32, REG_W = 5, WB_N = 2;

    logic clk, rst, alloc_valid, alloc_ready, alloc_pred_taken;
    logic [TAG_W-1:0] alloc_tag, q_tag1, q_tag2, cm_store_tag, count;
    logic [1:0] alloc_kind;
    logic [REG_W-1:0] alloc_dest, cm_reg_tag;
    logic [WB_N*TAG_W-1:0] wb_tag;
    logic [WB_N*DATA_W-1:0] wb_value;
    logic [WB_N-1:0] wb_taken;
    logic q_ready1, q_ready2, flush, empty, full;
    logic [DATA_W-1:0] q_value1, q_value2, cm_reg_value, flush_addr;

    typedef struct packed {
        logic              is_store;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cm_t;

    cm_t exp_q[$];
    int tests = 0;
    int fails = 0;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W), .WB_N(WB_N)) dut (
        .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_kind(alloc_kind), .alloc_dest(alloc_dest), .alloc_pred_taken(alloc_pred_taken),
        .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
        .q_tag1(q_tag1), .q_tag2(q_tag2), .q_ready1(q_ready1), .q_ready2(q_ready2),
        .q_value1(q_value1), .q_value2(q_value2), .cm_reg_tag(cm_reg_tag), .cm_reg_value(cm_reg_value),
        .cm_store_tag(cm_store_tag), .flush(flush), .flush_addr(flush_addr),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // Scoreboard: every commit pulse must match the oldest expected commit.
    always @(negedge clk) begin
        cm_t got, e;
        if (!rst && (cm_reg_tag != '0 || cm_store_tag != '0)) begin
            got.is_store = (cm_store_tag != '0);
            got.tag      = got.is_store ? cm_store_tag : TAG_W'(cm_reg_tag);
            got.value    = got.is_store ? '0 : cm_reg_value;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_commit: got reg=%0d store=%0d, required no commit", cm_reg_tag, cm_store_tag);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL commit_order: got %h, required %h", got, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_kind = 2'd0; alloc_dest = '0; alloc_pred_taken = 1'b0;
        wb_tag = '0; wb_value = '0; wb_taken = '0; q_tag1 = '0; q_tag2 = '0;
    endtask

    task automatic alloc1(input logic [1:0] kind, input logic [REG_W-1:0] dest, input logic pred);
        alloc_valid = 1'b1; alloc_kind = kind; alloc_dest = dest; alloc_pred_taken = pred;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        tests++;
        if ({count, empty, full, alloc_ready, alloc_tag, flush, flush_addr, cm_reg_tag, cm_store_tag} !==
            {4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 32'd0, 5'd0, 4'd0}) begin
            fails++;
            $display("FAIL reset_state: got count=%0d empty=%b full=%b ready=%b tag=%0d flush=%b, required 0 1 0 1 1 0",
                     count, empty, full, alloc_ready, alloc_tag, flush);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_dest = REG_W'(i + 1); alloc_pred_taken = 1'b0;
            #1;
            tests++;
            if ({alloc_ready, alloc_tag} !== {1'b1, TAG_W'(i + 1)}) begin
                fails++;
                $display("FAIL fill_tag: got ready=%b tag=%0d, required 1 %0d", alloc_ready, alloc_tag, i + 1);
            end
            tick();
        end
        alloc_valid = 1'b0;
        #1;
        tests++;
        if ({full, alloc_ready, count, empty} !== {1'b1, 1'b0, 4'd4, 1'b0}) begin
            fails++;
            $display("FAIL fill_full: got full=%b ready=%b count=%0d empty=%b, required 1 0 4 0", full, alloc_ready, count, empty);
        end
        alloc_valid = 1'b1; alloc_dest = 5'd9;
        tick();
        alloc_valid = 1'b0;
        q_tag1 = 4'd1;
        #1;
        tests++;
        if ({count, q_ready1} !== {4'd4, 1'b0}) begin
            fails++;
            $display("FAIL fill_overflow: got count=%0d q_ready=%b, required 4 0", count, q_ready1);
        end
    endtask

    task automatic test_inorder_commit();
        logic exp_rdy;
        logic [DATA_W-1:0] exp_val;
`ifdef ROB_WB_BYPASS_EN
        exp_rdy = 1'b1; exp_val = 32'h22;
`else
        exp_rdy = 1'b0; exp_val = 32'h0;
`endif
        wb_tag = {4'd0, 4'd2}; wb_value = {32'd0, 32'h22}; q_tag1 = 4'd2;
        #1;
        tests++;
        if ({q_ready1, q_value1} !== {exp_rdy, exp_val}) begin
            fails++;
            $display("FAIL query_wb_cycle: got %b/%h, required %b/%h", q_ready1, q_value1, exp_rdy, exp_val);
        end
        tick();
        wb_tag = '0;
        #1;
        tests++;
        if ({q_ready1, q_value1, cm_reg_tag} !== {1'b1, 32'h22, 5'd0}) begin
            fails++;
            $display("FAIL query_stored: got %b/%h cm=%0d, required 1/00000022 cm=0", q_ready1, q_value1, cm_reg_tag);
        end
        exp_q.push_back('{1'b0, 4'd1, 32'h11});
        exp_q.push_back('{1'b0, 4'd2, 32'h22});
        wb_tag = {4'd0, 4'd1}; wb_value = {32'd0, 32'h11};
        tick();
        wb_tag = '0;
        tests++;
        if ({cm_reg_tag, count} !== {5'd0, 4'd4}) begin
            fails++;
            $display("FAIL commit_latency: got cm=%0d count=%0d, required 0 4", cm_reg_tag, count);
        end
        tick();
        tests++;
        if (count !== 4'd3) begin
            fails++;
            $display("FAIL commit_count1: got %0d, required 3", count);
        end
        tick();
        tick();
        q_tag1 = 4'd1;
        #1;
        tests++;
        if ({count, cm_reg_tag, q_ready1, exp_q.size() == 0} !== {4'd2, 5'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL commit_remaining: got count=%0d cm=%0d q_ready=%b pending=%0d, required 2 0 0 0",
                     count, cm_reg_tag, q_ready1, exp_q.size());
        end
    endtask

    task automatic test_dual_wb();
        exp_q.push_back('{1'b0, 4'd3, 32'hB});
        wb_tag = {4'd3, 4'd3}; wb_value = {32'hB, 32'hA};
        tick();
        wb_tag = '0; q_tag2 = 4'd3;
        #1;
        tests++;
        if ({q_ready2, q_value2} !== {1'b1, 32'hB}) begin
            fails++;
            $display("FAIL dual_wb_priority: got %b/%h, required 1/0000000b", q_ready2, q_value2);
        end
        exp_q.push_back('{1'b0, 4'd4, 32'h44});
        wb_tag = {4'd0, 4'd4}; wb_value = {32'd0, 32'h44};
        tick();
        wb_tag = '0;
        tick();
        tick();
        tests++;
        if ({empty, count, alloc_tag, exp_q.size() == 0} !== {1'b1, 4'd0, 4'd1, 1'b1}) begin
            fails++;
            $display("FAIL drain_wrap: got empty=%b count=%0d tag=%0d pending=%0d, required 1 0 1 0",
                     empty, count, alloc_tag, exp_q.size());
        end
    endtask

    task automatic test_flush();
        wb_tag = {4'd0, 4'd1}; wb_value = {32'd0, 32'h99}; wb_taken = 2'b01;
        tick();
        wb_tag = '0; wb_taken = '0;
        alloc1(2'd2, 5'd0, 1'b0);
        alloc1(2'd0, 5'd5, 1'b0);
        q_tag1 = 4'd1;
        #1;
        tests++;
        if (q_ready1 !== 1'b0) begin
            fails++;
            $display("FAIL stale_wb_ignored: got q_ready=%b, required 0", q_ready1);
        end
        wb_tag = {4'd2, 4'd1}; wb_value = {32'h55, 32'h100}; wb_taken = 2'b01;
        tick();
        wb_tag = '0; wb_taken = '0;
        alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_dest = 5'd9;
        #1;
        tests++;
        if (alloc_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_blocks_alloc: got alloc_ready=%b, required 0", alloc_ready);
        end
        tick();
        alloc_valid = 1'b0;
        tests++;
        if ({flush, flush_addr, empty, count, cm_reg_tag} !== {1'b1, 32'h100, 1'b1, 4'd0, 5'd0}) begin
            fails++;
            $display("FAIL flush_pulse: got flush=%b addr=%h empty=%b count=%0d cm=%0d, required 1 00000100 1 0 0",
                     flush, flush_addr, empty, count, cm_reg_tag);
        end
        tick();
        tests++;
        if ({flush, flush_addr, empty, alloc_tag} !== {1'b0, 32'h0, 1'b1, 4'd1}) begin
            fails++;
            $display("FAIL flush_after: got flush=%b addr=%h empty=%b tag=%0d, required 0 0 1 1", flush, flush_addr, empty, alloc_tag);
        end
    endtask

    task automatic test_branch_ok();
        alloc1(2'd2, 5'd0, 1'b1);
        wb_tag = {4'd0, 4'd1}; wb_value = {32'd0, 32'h300}; wb_taken = 2'b01;
        tick();
        wb_tag = '0; wb_taken = '0;
        tick();
        tests++;
        if ({flush, count, empty, alloc_tag} !== {1'b0, 4'd0, 1'b1, 4'd2}) begin
            fails++;
            $display("FAIL branch_silent: got flush=%b count=%0d empty=%b tag=%0d, required 0 0 1 2", flush, count, empty, alloc_tag);
        end
        alloc1(2'd3, 5'd0, 1'b0);
        wb_tag = {4'd2, 4'd0}; wb_value = {32'h200, 32'd0};
        tick();
        wb_tag = '0;
        tests++;
        if (alloc_ready !== 1'b0) begin
            fails++;
            $display("FAIL jalr_blocks_alloc: got alloc_ready=%b, required 0", alloc_ready);
        end
        tick();
        tests++;
        if ({flush, flush_addr, count} !== {1'b1, 32'h200, 4'd0}) begin
            fails++;
            $display("FAIL jalr_flush: got flush=%b addr=%h count=%0d, required 1 00000200 0", flush, flush_addr, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [TAG_W-1:0] prev_tag, exp_tag;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev_tag = '0;
        for (int i = 0; i < 10; i++) begin
            exp_tag = TAG_W'((i % DEPTH) + 1);
            alloc_valid = 1'b1; alloc_kind = 2'd1; alloc_dest = '0;
            if (i > 0) begin
                wb_tag = {4'd0, prev_tag};
                exp_q.push_back('{1'b1, prev_tag, 32'd0});
            end else begin
                wb_tag = '0;
            end
            #1;
            tests++;
            if ({alloc_ready, alloc_tag} !== {1'b1, exp_tag}) begin
                fails++;
                $display("FAIL wrap_alloc_tag: got ready=%b tag=%0d, required 1 %0d", alloc_ready, alloc_tag, exp_tag);
            end
            tick();
            tests++;
            if (count > 4'd4) begin
                fails++;
                $display("FAIL wrap_count: got %0d, required <= 4", count);
            end
            prev_tag = exp_tag;
        end
        alloc_valid = 1'b0; wb_tag = '0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({cm_store_tag, cm_reg_tag, flush, count, empty, alloc_ready} !== {4'd0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset: got store=%0d reg=%0d flush=%b count=%0d empty=%b ready=%b, required 0 0 0 0 1 1",
                     cm_store_tag, cm_reg_tag, flush, count, empty, alloc_ready);
        end
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({empty, cm_store_tag} !== {1'b1, 4'd0}) begin
            fails++;
            $display("FAIL after_reset: got empty=%b store=%0d, required 1 0", empty, cm_store_tag);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_inorder_commit();
        test_dual_wb();
        test_flush();
        test_branch_ok();
        test_back_to_back();
        tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending commits, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised in-order reorder buffer for the out-of-order core. It sits between the decoder/dispatch stage, the writeback buses (ALU CDB, load/store CDB and any further units) and the retirement consumers (register file, LS queue, fetch redirect). It generalises the single-issue ROB in four ways: configurable depth and widths, N writeback ports, a valid/ready allocation handshake, and a full pipeline flush on misprediction.

## Interface
Parameters:
- DEPTH, 8: number of entries; must be a power of two, at least 2.
- TAG_W, 4: tag width; must satisfy 2^TAG_W > DEPTH. Tag 0 means "none"; entry i carries tag i+1.
- DATA_W, 32: value and PC width.
- REG_W, 5: architectural register index width.
- WB_N, 2: number of writeback ports.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_ready  out  1  entry can be accepted this cycle.
- alloc_tag  out  TAG_W  tag that the next accepted allocation receives (tail+1).
- alloc_kind  in  2  0 = reg write, 1 = store, 2 = branch, 3 = jalr.
- alloc_dest  in  REG_W  destination register.
- alloc_pred_taken  in  1  predicted direction.
- wb_tag  in  WB_N*TAG_W  per-port writeback tag; 0 = idle.
- wb_value  in  WB_N*DATA_W  per-port value; for branch/jalr this is the correct target.
- wb_taken  in  WB_N  per-port resolved direction.
- q_tag1, q_tag2  in  TAG_W  operand query tags.
- q_ready1, q_ready2  out  1  queried entry holds its result.
- q_value1, q_value2  out  DATA_W  queried value.
- cm_reg_tag  out  REG_W  retiring register index; 0 = none.
- cm_reg_value  out  DATA_W  retiring value.
- cm_store_tag  out  TAG_W  tag of the retiring store; 0 = none.
- flush  out  1  misprediction redirect pulse.
- flush_addr  out  DATA_W  correct fetch address.
- count  out  TAG_W  number of occupied entries.
- empty, full  out  1  occupancy flags.

## Operation
- Storage is a circular buffer with head and tail pointers of width log2(DEPTH) plus a count. Each entry holds valid, ready, kind, dest, pred_taken, taken and value. Pointers wrap modulo DEPTH.
- alloc_ready = !full && !flush_cond.
  - flush_cond = the head entry is valid and ready, and it is jalr, or it is a branch with taken != pred_taken.
- An allocation is accepted when alloc_valid && alloc_ready. The entry at tail is written with valid=1 and ready=0, tail advances, and count increments.
- Writeback: for each port p with a nonzero tag that matches a valid entry, write value and taken and set ready=1.
  - A tag that matches an invalid entry is ignored.
  - If two ports carry the same tag, the higher-indexed port wins.
- Commit: at most one entry per cycle, and only when the head entry is valid and ready as stored (same-cycle writeback does not count).
  - Reg write: cm_reg_tag = dest, cm_reg_value = value.
  - Store: cm_store_tag = head tag.
  - Branch, correctly predicted: retires silently.
  - flush_cond: flush=1, flush_addr = value. At the next edge every entry is invalidated and head = tail = count = 0.
  - Otherwise the head entry is invalidated, head advances, and count decrements.
- Commit and alloc in the same cycle: count is unchanged. A full buffer does not accept alloc in the same cycle it commits.
- Query is combinational. Tag 0, or a tag for an invalid entry, returns ready=0, value=0. Otherwise it returns the stored ready and value.

## Timing
- Reset (asynchronous): all entries invalid, head=tail=count=0, empty=1, full=0. All commit outputs, flush and flush_addr are 0.
- The commit outputs, flush and flush_addr are registered one-cycle pulses. They return to 0 on the next cycle unless another commit occurs.
- An allocated entry is queryable the cycle after acceptance. A writeback is visible to query the cycle after the edge.
- Minimum latency from writeback to commit output: 2 edges (ready set at edge 1, commit registered at edge 2).
- The flush edge invalidates everything, including entries written back or allocated in that cycle. flush_cond blocks alloc_ready in that cycle.
- Reset asserted mid-operation clears state immediately; in-flight pulses are dropped.

## Configuration
- ROB_WB_BYPASS_EN defined: a query whose tag matches any active wb_tag in the same cycle returns ready=1 and that port's value (highest port wins). The match is against the tag of a valid entry.
- Undefined: query reflects stored state only. The one-cycle writeback-to-query gap remains.

## Test plan
- DEPTH=4; allocate 4 reg-write entries (dest 1..4). Expect tags 1,2,3,4, full=1, alloc_ready=0, count=4.
- Write back tag 2 = 0x22, then tag 1 = 0x11. Expect cm_reg_tag=1/0x11, then 2/0x22 on consecutive cycles; tags 3 and 4 remain.
- Branch with pred_taken=0 and writeback taken=1, value 0x100, with a younger entry already ready. Expect flush=1, flush_addr=0x100, then empty=1 and count=0 with no commit from the younger entry.
- Same-cycle writeback on two ports to tag 3 (0xA from port 0, 0xB from port 1). Expect stored value 0xB.
- Query tag 2 in the writeback cycle. Expect ready=1, value=0x22 with ROB_WB_BYPASS_EN defined; ready=0 without it.
- Wrap-around: alloc and commit stores continuously for 10 entries. Expect cm_store_tag sequence 1,2,3,4,1,2,…; count never exceeds 4. Then rst mid-stream: outputs 0 and empty=1 immediately.
